// File: rtl/commit_trace_monitor.sv
// Commit trace monitor: watches the core's debug bus, turns register writes, stores and halt
// into a buffered ready/valid trace stream, and keeps cycle/fetch/drop counters.
module commit_trace_monitor #(
    parameter int          DEPTH       = 16,
    parameter logic [3:0]  FETCH_STATE = 4'd0,
    parameter logic [31:0] HALT_INSTR  = 32'hEAFFFFFE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  state,
    input  logic [31:0] PC,
    input  logic [31:0] Instr,
    input  logic        RegWrite,
    input  logic [3:0]  Rd,
    input  logic [3:0]  Ra,
    input  logic        IsLongMul,
    input  logic [31:0] Result,
    input  logic [31:0] ALUResult2,
    input  logic        MemWrite,
    input  logic [31:0] Adr,
    input  logic [31:0] WriteData,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [1:0]  trace_kind,
    output logic [31:0] trace_pc,
    output logic [31:0] trace_tag,
    output logic [31:0] trace_data,
    output logic [31:0] cycle_count,
    output logic [31:0] fetch_count,
    output logic [15:0] drop_count,
    output logic        halted
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        KIND_REG  = 2'd0,
        KIND_MEM  = 2'd1,
        KIND_HALT = 2'd2
    } kind_e;

    typedef struct packed {
        kind_e       kind;
        logic [31:0] pc;
        logic [31:0] tag;
        logic [31:0] data;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [31:0]   cur_pc;

    logic          is_fetch;
    logic          halt_det;
    logic          pop;
    entry_t        push_e0;
    entry_t        push_e1;
    entry_t        reg_lo_e;
    entry_t        reg_hi_e;
    entry_t        mem_e;
    entry_t        halt_e;
    entry_t        head;
    logic [1:0]    n_req;
    logic [1:0]    n_acc;
    logic [1:0]    n_drop;
    logic [AW+1:0] free;
    logic [16:0]   drop_sum;

    assign trace_valid = (count != '0);
    assign head        = mem[rd_ptr];
    assign pop         = trace_valid && trace_ready;

    // Unused memory slots hold stale data, so the visible head is forced to zero when empty.
    assign trace_kind  = trace_valid ? head.kind : 2'd0;
    assign trace_pc    = trace_valid ? head.pc   : 32'd0;
    assign trace_tag   = trace_valid ? head.tag  : 32'd0;
    assign trace_data  = trace_valid ? head.data : 32'd0;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        is_fetch = (state == FETCH_STATE);
        // A branch-to-self that has already executed refetches at the PC it was fetched from.
        halt_det = is_fetch && (Instr == HALT_INSTR) && (PC == cur_pc) && !halted;

        reg_lo_e = '{kind: KIND_REG,  pc: cur_pc, tag: {28'd0, Rd}, data: Result};
        reg_hi_e = '{kind: KIND_REG,  pc: cur_pc, tag: {28'd0, Ra}, data: ALUResult2};
        mem_e    = '{kind: KIND_MEM,  pc: cur_pc, tag: Adr,         data: WriteData};
        // The halt entry reports the count including the halt cycle, i.e. the frozen value.
        halt_e   = '{kind: KIND_HALT, pc: cur_pc, tag: 32'd0,       data: cycle_count + 32'd1};

        push_e0 = '0;
        push_e1 = '0;
        n_req   = 2'd0;
        if (!halted) begin
            if (RegWrite) begin
                push_e0 = reg_lo_e;
                n_req   = 2'd1;
                if (IsLongMul) begin
                    push_e1 = reg_hi_e;
                    n_req   = 2'd2;
                end else if (halt_det) begin
                    push_e1 = halt_e;
                    n_req   = 2'd2;
                end
            end else if (MemWrite) begin
                push_e0 = mem_e;
                n_req   = 2'd1;
                if (halt_det) begin
                    push_e1 = halt_e;
                    n_req   = 2'd2;
                end
            end else if (halt_det) begin
                push_e0 = halt_e;
                n_req   = 2'd1;
            end
        end

        free = (AW+2)'(DEPTH) - (AW+2)'(count) + (AW+2)'(pop);
        if (free >= (AW+2)'(n_req)) n_acc = n_req;
        else                        n_acc = free[1:0];
        n_drop   = n_req - n_acc;
        drop_sum = {1'b0, drop_count} + 17'(n_drop);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            cur_pc      <= 32'd0;
            cycle_count <= 32'd0;
            fetch_count <= 32'd0;
            drop_count  <= 16'd0;
            halted      <= 1'b0;
        end else begin
            if (is_fetch) cur_pc <= PC;
            wr_ptr <= wr_ptr + AW'(n_acc);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + (AW+1)'(n_acc) - (AW+1)'(pop);
            if (n_drop != 2'd0)
                drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            if (!halted) begin
                cycle_count <= cycle_count + 32'd1;
                if (is_fetch) fetch_count <= fetch_count + 32'd1;
                if (halt_det) halted <= 1'b1;
            end
        end
    end

    // NOTE: the storage array is deliberately not reset; count gates visibility of its contents.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (n_acc != 2'd0) mem[wr_ptr] <= push_e0;
            if (n_acc == 2'd2) mem[wr_ptr + AW'(1)] <= push_e1;
        end
    end

    // The core never writes the register file and memory in the same cycle.
    a_no_reg_and_mem : assert property (@(posedge clk) disable iff (reset) !(RegWrite && MemWrite));

endmodule

// File: tb/tb_commit_trace_monitor.sv
// Directed self-checking bench for commit_trace_monitor with hand-computed expectations.
module tb_commit_trace_monitor;

    localparam int DEPTH = 16;

    logic        clk;
    logic        reset;
    logic [3:0]  state;
    logic [31:0] PC, Instr, Result, ALUResult2, Adr, WriteData;
    logic        RegWrite, IsLongMul, MemWrite, trace_ready;
    logic [3:0]  Rd, Ra;
    logic        trace_valid, halted;
    logic [1:0]  trace_kind;
    logic [31:0] trace_pc, trace_tag, trace_data, cycle_count, fetch_count;
    logic [15:0] drop_count;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_cyc  = 0;
    logic [31:0] exp_fetch = 0;
    bit          exp_halted = 0;

    commit_trace_monitor #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .state(state), .PC(PC), .Instr(Instr),
        .RegWrite(RegWrite), .Rd(Rd), .Ra(Ra), .IsLongMul(IsLongMul),
        .Result(Result), .ALUResult2(ALUResult2), .MemWrite(MemWrite),
        .Adr(Adr), .WriteData(WriteData), .trace_valid(trace_valid),
        .trace_ready(trace_ready), .trace_kind(trace_kind), .trace_pc(trace_pc),
        .trace_tag(trace_tag), .trace_data(trace_data), .cycle_count(cycle_count),
        .fetch_count(fetch_count), .drop_count(drop_count), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic [1:0] kind, input logic [31:0] pc,
                              input logic [31:0] t, input logic [31:0] d);
        check({tag, ".valid"}, trace_valid, 1);
        check({tag, ".kind"},  trace_kind, kind);
        check({tag, ".pc"},    trace_pc, pc);
        check({tag, ".tag"},   trace_tag, t);
        check({tag, ".data"},  trace_data, d);
    endtask

    // Advance one clock; the bench's own counter model tracks what the DUT should count.
    task automatic step();
        if (reset) begin
            exp_cyc   = 0;
            exp_fetch = 0;
        end else if (!exp_halted) begin
            exp_cyc++;
            if (state == 4'd0) exp_fetch++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        state = 4'd1; PC = 0; Instr = 0; RegWrite = 0; IsLongMul = 0; MemWrite = 0;
        Rd = 0; Ra = 0; Result = 0; ALUResult2 = 0; Adr = 0; WriteData = 0;
    endtask

    task automatic push_reg(input logic [3:0] r, input logic [31:0] v);
        RegWrite = 1; Rd = r; Result = v;
        step();
        RegWrite = 0;
    endtask

    initial begin
        idle();
        trace_ready = 0;
        reset = 1;
        repeat (3) step();
        check("rst.valid", trace_valid, 0);
        check("rst.halted", halted, 0);
        check("rst.cycle", cycle_count, 0);
        check("rst.fetch", fetch_count, 0);
        check("rst.drop", drop_count, 0);
        check("rst.data", trace_data, 0);

        // 1: single fetch at PC 0x8
        reset = 0;
        state = 4'd0; PC = 32'h8;
        step();
        idle();
        check("t1.fetch", fetch_count, 1);
        check("t1.cycle", cycle_count, 1);
        check("t1.valid", trace_valid, 0);
        check("t1.halted", halted, 0);

        // 2: register write seen for exactly one cycle with ready high
        trace_ready = 1;
        push_reg(4'd3, 32'h55);
        check_head("t2", 2'd0, 32'h8, 32'd3, 32'h55);
        step();
        check("t2.gone", trace_valid, 0);
        check("t2.cycle", cycle_count, exp_cyc);

        // 3: long multiply pushes RdLo then RdHi; head holds while not ready
        trace_ready = 0;
        state = 4'd0; PC = 32'hC;
        step();
        idle();
        RegWrite = 1; IsLongMul = 1; Rd = 4'd4; Ra = 4'd5; Result = 32'hFFFFFFFE; ALUResult2 = 32'h1;
        step();
        idle();
        check_head("t3.lo", 2'd0, 32'hC, 32'd4, 32'hFFFFFFFE);
        repeat (2) step();
        check_head("t3.hold", 2'd0, 32'hC, 32'd4, 32'hFFFFFFFE);
        trace_ready = 1;
        step();
        check_head("t3.hi", 2'd0, 32'hC, 32'd5, 32'h1);
        step();
        check("t3.empty", trace_valid, 0);

        // 4: overflow with DEPTH+3 single pushes, then drain in order
        trace_ready = 0;
        for (int i = 0; i < DEPTH + 3; i++) push_reg(4'(i), 32'h100 + 32'(i));
        check("t4.drop", drop_count, 3);
        check("t4.valid", trace_valid, 1);
        trace_ready = 1;
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("t4.drain%0d", i), trace_data, 32'h100 + 32'(i));
            step();
        end
        check("t4.empty", trace_valid, 0);
        check("t4.drop_hold", drop_count, 3);

        // 4b: two pushes with one free slot keep the first, drop the second
        trace_ready = 0;
        for (int i = 0; i < DEPTH - 1; i++) push_reg(4'd1, 32'(i));
        RegWrite = 1; IsLongMul = 1; Rd = 4'd7; Ra = 4'd8; Result = 32'hAA; ALUResult2 = 32'hBB;
        step();
        idle();
        check("t4b.drop", drop_count, 4);
        trace_ready = 1;
        repeat (DEPTH - 1) step();
        check_head("t4b.last", 2'd0, 32'hC, 32'd7, 32'hAA);
        step();
        check("t4b.empty", trace_valid, 0);

        // 5: store entry, then branch-to-self fetched twice halts the monitor
        trace_ready = 0;
        MemWrite = 1; Adr = 32'h64; WriteData = 32'h7;
        step();
        idle();
        check_head("t5.mem", 2'd1, 32'hC, 32'h64, 32'h7);
        state = 4'd0; PC = 32'h3C; Instr = 32'hEAFFFFFE;
        step();
        check("t5.not_yet", halted, 0);
        state = 4'd1;
        step();
        state = 4'd0;
        step();
        exp_halted = 1;
        idle();
        check("t5.halted", halted, 1);
        check("t5.cycle", cycle_count, exp_cyc);
        check("t5.fetch", fetch_count, exp_fetch);
        RegWrite = 1; Rd = 4'd9; Result = 32'h99; state = 4'd0;
        repeat (2) step();
        idle();
        check("t5.cycle_frozen", cycle_count, exp_cyc);
        check("t5.fetch_frozen", fetch_count, exp_fetch);
        trace_ready = 1;
        step();
        check_head("t5.halt", 2'd2, 32'h3C, 32'd0, exp_cyc);
        step();
        check("t5.no_more", trace_valid, 0);

        // 6: reset with five entries queued and halted set
        reset = 1;
        step();
        reset = 0;
        exp_halted = 0;
        trace_ready = 0;
        for (int i = 0; i < 4; i++) push_reg(4'(i), 32'(i));
        state = 4'd0; PC = 32'h3C; Instr = 32'hEAFFFFFE;
        step();
        step();
        exp_halted = 1;
        idle();
        check("t6.halted", halted, 1);
        check("t6.kind_pre", trace_kind, 0);
        reset = 1;
        step();
        exp_halted = 0;
        check("t6.valid", trace_valid, 0);
        check("t6.kind", trace_kind, 0);
        check("t6.pc", trace_pc, 0);
        check("t6.tag", trace_tag, 0);
        check("t6.data", trace_data, 0);
        check("t6.halted_clr", halted, 0);
        check("t6.cycle", cycle_count, 0);
        check("t6.fetch", fetch_count, 0);
        check("t6.drop", drop_count, 0);
        reset = 0;
        step();
        check("t6.still_empty", trace_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
